// File: rtl/div8_seq.sv
// rtl/div8_seq.sv - multi-cycle restoring divider, one quotient bit per clock
// Optional feature: define DIV_SIGNED_EN for two's-complement operands (default build is unsigned).
module div8_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]    CNT_LOAD = CW'(WIDTH - 1);
    localparam logic [WIDTH+1:0] ONE      = {{(WIDTH+1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rmd_q, rmd_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   rem_sh;
    logic [WIDTH+1:0] trial_sum;
    logic             carry;
    logic [WIDTH-1:0] q_next, r_next;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH-1:0] fix_q, fix_r;
    logic             unused_trial_msb;

`ifdef DIV_SIGNED_EN
    logic negq_q, negq_d;
    logic negr_q, negr_d;
`endif

    // Trial subtraction: rem_sh + ~divisor + 1; carry-out set means no borrow.
    always_comb begin
        rem_sh    = {rem_q, dvd_q[WIDTH-1]};
        trial_sum = {1'b0, rem_sh} + {2'b01, ~dvs_q} + ONE;
        carry     = trial_sum[WIDTH+1];
        q_next    = {dvd_q[WIDTH-2:0], carry};
        r_next    = carry ? trial_sum[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    end

    assign unused_trial_msb = trial_sum[WIDTH];

`ifdef DIV_SIGNED_EN
    // Magnitudes are divided; most-negative maps to itself, which reads correctly as unsigned.
    always_comb begin
        mag_a  = dividend[WIDTH-1] ? -dividend : dividend;
        mag_b  = divisor[WIDTH-1]  ? -divisor  : divisor;
        negq_d = negq_q;
        negr_d = negr_q;
        if (state_q == S_IDLE && start) begin
            negq_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
            negr_d = dividend[WIDTH-1];
        end
        fix_q = negq_q ? -q_next : q_next;
        fix_r = negr_q ? -r_next : r_next;
    end
`else
    always_comb begin
        mag_a = dividend;
        mag_b = divisor;
        fix_q = q_next;
        fix_r = r_next;
    end
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        quo_d   = quo_q;
        rmd_d   = rmd_q;
        dbz_d   = dbz_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cnt_d = CNT_LOAD;
                    rem_d = '0;
                    dvd_d = mag_a;
                    dvs_d = mag_b;
                    dbz_d = 1'b0;
                    if (divisor == '0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        quo_d   = '1;
                        rmd_d   = dividend;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = S_CALC;
                        busy_d  = 1'b1;
                    end
                end
            end
            S_CALC: begin
                rem_d = r_next;
                dvd_d = q_next;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    quo_d   = fix_q;
                    rmd_d   = fix_r;
                end else begin
                    busy_d = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            quo_q   <= '0;
            rmd_q   <= '0;
            dbz_q   <= 1'b0;
`ifdef DIV_SIGNED_EN
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            quo_q   <= quo_d;
            rmd_q   <= rmd_d;
            dbz_q   <= dbz_d;
`ifdef DIV_SIGNED_EN
            negq_q  <= negq_d;
            negr_q  <= negr_d;
`endif
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quo_q;
    assign remainder   = rmd_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div8_seq.sv
// tb/tb_div8_seq.sv - randomized bench for div8_seq against an arithmetic timing/result model
module tb_div8_seq;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy, done, div_by_zero;
    logic [W-1:0] quotient, remainder;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    div8_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done), .quotient(quotient),
        .remainder(remainder), .div_by_zero(div_by_zero)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference result from plain arithmetic.
    task automatic ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                           output logic z, output logic [W-1:0] q, output logic [W-1:0] r);
        z = (b == 0);
        if (b == 0) begin
            q = '1;
            r = a;
        end else begin
`ifdef DIV_SIGNED_EN
            int sa, sb;
            sa = $signed(a);
            sb = $signed(b);
            if (sa == -(1 << (W-1)) && sb == -1) begin
                q = a;
                r = '0;
            end else begin
                q = W'(sa / sb);
                r = W'(sa % sb);
            end
`else
            q = a / b;
            r = a % b;
`endif
        end
    endtask

    // Timing model: an accepted start at edge t0 finishes at t0+W (t0 if divisor is 0);
    // the next start can be accepted two edges after the finishing edge.
    int           cyc = 0, t0 = -100, t_done = -100, free_at = 0;
    bit           model_ok = 0;
    logic         m_busy = 0, m_done = 0, m_z = 0, p_z = 0;
    logic [W-1:0] m_q = '0, m_r = '0, p_q = '0, p_r = '0;

    always @(posedge clk) begin
        if (!rst_n) begin
            free_at  = cyc + 1;
            t0       = -100;
            t_done   = -100;
            m_busy   = 0;
            m_done   = 0;
            m_z      = 0;
            m_q      = '0;
            m_r      = '0;
            model_ok = 1;
        end else begin
            if (cyc >= free_at && start) begin
                ref_div(dividend, divisor, p_z, p_q, p_r);
                t0      = cyc;
                t_done  = cyc + (p_z ? 0 : W);
                free_at = t_done + 2;
                m_z     = 0;
            end
            m_busy = (cyc >= t0 && cyc < t_done);
            m_done = (cyc == t_done);
            if (cyc == t_done) begin
                m_q = p_q;
                m_r = p_r;
                m_z = p_z;
            end
        end
        cyc++;
    end

    always @(negedge clk) begin
        if (model_ok) begin
            check("busy", busy, m_busy);
            check("done", done, m_done);
            check("quotient", quotient, m_q);
            check("remainder", remainder, m_r);
            check("div_by_zero", div_by_zero, m_z);
        end
    end

    // Issues one operation from IDLE and stops at the negedge where done is seen.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, output int busy_cnt);
        bit got;
        @(negedge clk);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(negedge clk);
        start    = 1'b0;
        dividend = W'($urandom);
        divisor  = W'($urandom);
        busy_cnt = 0;
        got      = 0;
        for (int i = 0; i < W + 4 && !got; i++) begin
            if (busy) busy_cnt++;
            if (done) got = 1;
            else @(negedge clk);
        end
        check("done_timeout", got, 1'b1);
    endtask

    int bc;
    int n_done;

    initial begin
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_q", quotient, 0);
        check("rst_dbz", div_by_zero, 1'b0);
        rst_n = 1'b1;

`ifndef DIV_SIGNED_EN
        run_op(8'd200, 8'd7, bc);
        check("t2_q", quotient, 8'h1C);
        check("t2_r", remainder, 8'd4);
        check("t2_busy_cycles", bc, 8);
        run_op(8'hFF, 8'h01, bc);
        check("t3a_q", quotient, 8'hFF);
        check("t3a_r", remainder, 8'h00);
        run_op(8'd5, 8'd9, bc);
        check("t3b_q", quotient, 8'h00);
        check("t3b_r", remainder, 8'd5);
`else
        run_op(8'hF9, 8'h02, bc);
        check("t6a_q", quotient, 8'hFD);
        check("t6a_r", remainder, 8'hFF);
        check("t6a_busy_cycles", bc, 8);
        run_op(8'h80, 8'hFF, bc);
        check("t6b_q", quotient, 8'h80);
        check("t6b_r", remainder, 8'h00);
        run_op(8'h07, 8'hFE, bc);
        check("t6c_q", quotient, 8'hFD);
        check("t6c_r", remainder, 8'h01);
`endif

        run_op(8'h2A, 8'h00, bc);
        check("t4_busy_cycles", bc, 0);
        check("t4_q", quotient, 8'hFF);
        check("t4_r", remainder, 8'h2A);
        check("t4_dbz", div_by_zero, 1'b1);
        run_op(8'd9, 8'd3, bc);
        check("t4_dbz_cleared", div_by_zero, 1'b0);
        check("t4_next_q", quotient, 8'd3);

        // Reset asserted mid-calculation.
        @(negedge clk);
        start    = 1'b1;
        dividend = 8'd100;
        divisor  = 8'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        check("t1_busy", busy, 1'b0);
        check("t1_q", quotient, 0);
        check("t1_r", remainder, 0);
        @(negedge clk);
        rst_n  = 1'b1;
        n_done = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("t1_no_done", n_done, 0);

        // Start held high: three accepts in 3*(W+2) cycles, one-cycle done each.
        n_done   = 0;
        start    = 1'b1;
        dividend = 8'd77;
        divisor  = 8'd5;
        for (int i = 0; i < 3 * (W + 2); i++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        start = 1'b0;
        check("t5_dones", n_done, 3);

        repeat (1500) begin
            @(negedge clk);
            start    = ($urandom % 3 == 0);
            dividend = W'($urandom);
            divisor  = ($urandom % 8 == 0) ? '0 : W'($urandom);
            if ($urandom % 16 == 0) begin
                dividend = 8'h80;
                divisor  = 8'hFF;
            end
        end
        start = 1'b0;
        repeat (W + 4) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
